sprite_line_fetcher: RTL

Read-side client of sprite storage. On a draw request it fetches one row of one sprite through a storage read port (select/addr/4-bit data, 1-cycle registered read latency). It writes the non-transparent pixels into a scanline buffer at a given x offset. It sits between the sprite scheduler (per-scanline draw list) and the line buffer that feeds the VGA output.

---
 rtl/sprite_pkg.sv | 42 ++++
 rtl/sprite_line_fetcher_if.sv | 46 ++++
 rtl/sprite_line_fetcher.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_pkg
// Purpose  : Sprite geometry, line width and fetcher state shared by storage,
//            SPI writer and line fetcher.
// Revision : 1.0
// ============================================================================
package sprite_pkg;

  localparam int SPRITE_NUM    = 8;
  localparam int SPRITE_WIDTH  = 32;
  localparam int SPRITE_HEIGHT = 32;
  localparam int SPRITE_SIZE   = SPRITE_WIDTH * SPRITE_HEIGHT;
  localparam int LINE_WIDTH    = 640;
  localparam logic [3:0] TRANSPARENT = 4'h0;

  localparam int ID_W   = $clog2(SPRITE_NUM);
  localparam int ROW_W  = $clog2(SPRITE_HEIGHT) + 1;
  localparam int COL_W  = $clog2(SPRITE_WIDTH);
  localparam int ADDR_W = $clog2(SPRITE_SIZE);
  localparam int X_W    = $clog2(LINE_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

  // Storage nibble address of a row/column; flip mirrors the column index.
  function automatic logic [ADDR_W-1:0] fetch_addr(
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col,
    input logic             flip
  );
    logic [COL_W-1:0] c;
    c = flip ? (COL_W'(SPRITE_WIDTH - 1) - col) : col;
    return (ADDR_W'(row) * ADDR_W'(SPRITE_WIDTH)) + ADDR_W'(c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_line_fetcher_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_line_fetcher_if
// Purpose  : Request, storage-read and line-buffer-write signals of the line
//            fetcher. Optional hflip port under SPRITE_HFLIP_EN.
// Revision : 1.0
// ============================================================================
interface sprite_line_fetcher_if;
  import sprite_pkg::*;

  logic              start;
  logic              ready;
  logic [ID_W-1:0]   sprite_id;
  logic [ROW_W-1:0]  row;
  logic [X_W-1:0]    x_pos;
`ifdef SPRITE_HFLIP_EN
  logic              hflip;
`endif
  logic [ID_W-1:0]   r_select;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_data;
  logic              lb_w_en;
  logic [X_W-1:0]    lb_w_addr;
  logic [3:0]        lb_w_data;
  logic              done;

  // Environment side: scheduler, sprite storage and line buffer.
  modport master (
`ifdef SPRITE_HFLIP_EN
    output hflip,
`endif
    output start, sprite_id, row, x_pos, r_data,
    input  ready, done, r_select, r_addr, lb_w_en, lb_w_addr, lb_w_data
  );

  // Fetcher side.
  modport slave (
`ifdef SPRITE_HFLIP_EN
    input  hflip,
`endif
    input  start, sprite_id, row, x_pos, r_data,
    output ready, done, r_select, r_addr, lb_w_en, lb_w_addr, lb_w_data
  );

endinterface
`default_nettype wire

// File: rtl/sprite_line_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : sprite_line_fetcher
// Purpose  : Fetches one sprite row from storage and writes its opaque pixels
//            into the scanline buffer. SPRITE_HFLIP_EN adds mirrored drawing.
// Revision : 1.0
// ============================================================================
module sprite_line_fetcher
  import sprite_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  sprite_line_fetcher_if.slave fetch_if
);

  fetch_state_t      r_state;
  logic              r_ready;
  logic              r_done;
  logic [ID_W-1:0]   r_select;
  logic [ADDR_W-1:0] r_addr;
  logic [ROW_W-1:0]  r_row;
  logic [X_W-1:0]    r_x;
  logic              r_hflip;
  logic [COL_W-1:0]  r_col;
  logic              r_valid_d;
  logic [COL_W-1:0]  r_col_d;

  logic              w_hflip_in;
  logic              w_row_ok;
  logic [COL_W-1:0]  w_col_next;
  logic [X_W:0]      w_sum;
  logic              w_in_line;
  logic              w_wen;

`ifdef SPRITE_HFLIP_EN
  assign w_hflip_in = fetch_if.hflip;
`else
  assign w_hflip_in = 1'b0;
`endif

  assign w_row_ok   = (fetch_if.row < ROW_W'(SPRITE_HEIGHT));
  assign w_col_next = r_col + COL_W'(1);

  // Control FSM; r_col is the column whose address is on r_addr.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_select <= '0;
      r_addr   <= '0;
      r_row    <= '0;
      r_x      <= '0;
      r_hflip  <= 1'b0;
      r_col    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (fetch_if.start) begin
            r_row   <= fetch_if.row;
            r_x     <= fetch_if.x_pos;
            r_hflip <= w_hflip_in;
            r_ready <= 1'b0;
            if (w_row_ok) begin
              r_state  <= ST_FETCH;
              r_col    <= '0;
              r_select <= fetch_if.sprite_id;
              r_addr   <= fetch_addr(fetch_if.row, '0, w_hflip_in);
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (r_col == COL_W'(SPRITE_WIDTH - 1)) begin
            r_state <= ST_DRAIN;
          end else begin
            r_col  <= w_col_next;
            r_addr <= fetch_addr(r_row, w_col_next, r_hflip);
          end
        end
        ST_DRAIN: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Read-latency stage: tags the returning nibble with its screen column.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid_d <= 1'b0;
      r_col_d   <= '0;
    end else begin
      r_valid_d <= (r_state == ST_FETCH);
      r_col_d   <= r_col;
    end
  end

  assign w_sum     = {1'b0, r_x} + (X_W+1)'(r_col_d);
  assign w_in_line = (w_sum < (X_W+1)'(LINE_WIDTH));
  assign w_wen     = r_valid_d && (fetch_if.r_data != TRANSPARENT) && w_in_line;

  assign fetch_if.ready     = r_ready;
  assign fetch_if.done      = r_done;
  assign fetch_if.r_select  = r_select;
  assign fetch_if.r_addr    = r_addr;
  assign fetch_if.lb_w_en   = w_wen;
  assign fetch_if.lb_w_addr = r_valid_d ? w_sum[X_W-1:0] : '0;
  assign fetch_if.lb_w_data = r_valid_d ? fetch_if.r_data : 4'h0;

endmodule
`default_nettype wire
